// File: rtl/gray_incr_pkg.sv
// Shared definitions for gray_incr_arbiter: parameter defaults, the stage record and bin2gray.
// Stage records are sized for the largest supported build (WIDTH <= 32, NUM_REQ <= 8).
package gray_incr_pkg;

  localparam int WIDTH_DEF   = 32;
  localparam int NUM_REQ_DEF = 4;
  localparam int DATA_MAX_W  = 32;
  localparam int ID_MAX_W    = 3;

  typedef struct packed {
    logic                  valid;
    logic [ID_MAX_W-1:0]   id;
    logic [DATA_MAX_W-1:0] data;
    logic                  wrap;
  } stage_rec_t;

  function automatic logic [DATA_MAX_W-1:0] bin2gray(input logic [DATA_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_incr_arbiter_rr.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, searching upward modulo NUM_REQ.
module rr_arbiter
  import gray_incr_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0] idx;
  logic           found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + IDW'(i);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gray_incr_arbiter.sv
// Round-robin arbitrated, 2-stage pipelined binary increment to Gray code converter.
// Optional Gray-adjacency self-checker built when GRAY_INCR_CHECK_EN is defined.
module gray_incr_arbiter
  import gray_incr_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]           rsp_gray,
  output logic                       rsp_wrap,
  output logic                       chk_err
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     grant_idx;
  logic               pipe_en;
  logic               accept;
  logic [WIDTH-1:0]   operand;
  logic [WIDTH:0]     incr;
  stage_rec_t         stage_p1;
  stage_rec_t         stage_p2;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) grant_idx = IDW'(i);
    end
  end

  assign pipe_en   = !stage_p2.valid || rsp_ready;
  assign req_ready = (pipe_en && !reset) ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign operand   = req_data[int'(grant_idx)*WIDTH +: WIDTH];
  assign incr      = {1'b0, operand} + (WIDTH+1)'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr   <= '0;
      stage_p1 <= '0;
      stage_p2 <= '0;
    end else begin
      if (accept) rr_ptr <= grant_idx + IDW'(1);
      if (pipe_en) begin
        // p0 -> p1: accepted operand incremented, carry-out kept as wrap
        stage_p1.valid <= accept;
        stage_p1.id    <= ID_MAX_W'(grant_idx);
        stage_p1.data  <= DATA_MAX_W'(incr[WIDTH-1:0]);
        stage_p1.wrap  <= incr[WIDTH];
        // p1 -> p2: sum converted to Gray
        stage_p2.valid <= stage_p1.valid;
        stage_p2.id    <= stage_p1.id;
        stage_p2.data  <= bin2gray(stage_p1.data);
        stage_p2.wrap  <= stage_p1.wrap;
      end
    end
  end

  assign rsp_valid = stage_p2.valid;
  assign rsp_id    = IDW'(stage_p2.id);
  assign rsp_gray  = WIDTH'(stage_p2.data);
  assign rsp_wrap  = stage_p2.wrap;

`ifdef GRAY_INCR_CHECK_EN
  logic [WIDTH-1:0] ref_gray_p2;
  logic             chk_err_q;

  function automatic logic one_bit_set(input logic [WIDTH-1:0] x);
    return (x != '0) && ((x & (x - WIDTH'(1))) == '0);
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      ref_gray_p2 <= '0;
      chk_err_q   <= 1'b0;
    end else begin
      // p1 -> p2: Gray of the original operand (sum - 1) for the adjacency check
      if (pipe_en) ref_gray_p2 <= WIDTH'(bin2gray(DATA_MAX_W'(WIDTH'(stage_p1.data) - WIDTH'(1))));
      if (stage_p2.valid && rsp_ready && !one_bit_set(rsp_gray ^ ref_gray_p2)) chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_incr_arbiter.sv
// Randomized self-checking bench for gray_incr_arbiter against a transaction-level reference model.
module tb_gray_incr_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_gray;
  logic           rsp_wrap;
  logic           chk_err;

  gray_incr_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gray  (rsp_gray),
    .rsp_wrap  (rsp_wrap),
    .chk_err   (chk_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // reference model: two in-flight slots holding finished results, plus the pointer
  bit          m_v1, m_v2;
  int          m_id1, m_id2;
  logic [31:0] m_g1, m_g2;
  bit          m_w1, m_w2;
  int          m_ptr;

  int          obs_id[$];
  logic [31:0] obs_gray[$];
  bit          obs_wrap[$];

  bit          sweep_mode;
  bit          have_prev;
  logic [31:0] prev_gray;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] ref_result(input logic [31:0] op);
    logic [32:0] s;
    logic [31:0] v;
    s = {1'b0, op} + 33'd1;
    v = s[31:0];
    return {s[32], v ^ (v >> 1)};
  endfunction

  function automatic int ones(input logic [31:0] x);
    int c = 0;
    for (int b = 0; b < 32; b++) c += int'(x[b]);
    return c;
  endfunction

  // called at a negedge with inputs already driven; returns at the next negedge
  task automatic cycle();
    bit          en;
    int          g;
    logic [3:0]  exp_rdy;
    logic [32:0] r;
    #1;
    en = !m_v2 || rsp_ready;
    g  = -1;
    if (en && !reset) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_rdy = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    check_val("req_ready", req_ready, exp_rdy);
    check_val("rsp_valid", rsp_valid, m_v2);
    if (m_v2) begin
      check_val("rsp_id", rsp_id, m_id2);
      check_val("rsp_gray", rsp_gray, m_g2);
      check_val("rsp_wrap", rsp_wrap, m_w2);
    end
    check_val("chk_err", chk_err, 0);
    if (rsp_valid && rsp_ready) begin
      obs_id.push_back(int'(rsp_id));
      obs_gray.push_back(rsp_gray);
      obs_wrap.push_back(rsp_wrap);
      if (sweep_mode) begin
        if (have_prev) check_val("adjacent", ones(rsp_gray ^ prev_gray), 1);
        prev_gray = rsp_gray;
        have_prev = 1'b1;
      end
    end
    if (reset) begin
      m_v1 = 0; m_v2 = 0; m_ptr = 0;
    end else if (en) begin
      m_v2 = m_v1; m_id2 = m_id1; m_g2 = m_g1; m_w2 = m_w1;
      m_v1 = (g >= 0);
      if (g >= 0) begin
        r     = ref_result(req_data[g*W +: W]);
        m_id1 = g;
        m_g1  = r[31:0];
        m_w1  = r[32];
        m_ptr = (g + 1) % N;
      end
    end
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic clear_obs();
    obs_id.delete();
    obs_gray.delete();
    obs_wrap.delete();
  endtask

  logic [31:0] s_gray;
  int          s_id;
  bit          s_wrap;
  int          exp_ids[6] = '{0, 1, 2, 3, 0, 1};

  initial begin
    reset = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    m_v1 = 0; m_v2 = 0; m_ptr = 0; sweep_mode = 0; have_prev = 0;
    @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b0;

    // single operand 5 through requester 0
    clear_obs();
    req_valid = 4'b0001; req_data[0*W +: W] = 32'd5;
    cycle();
    idle(4);
    check_val("d5_count", obs_gray.size(), 1);
    if (obs_gray.size() >= 1) begin
      check_val("d5_gray", obs_gray[0], 32'h5);
      check_val("d5_id", obs_id[0], 0);
      check_val("d5_wrap", obs_wrap[0], 0);
    end

    // all-ones wraps, zero yields 1
    clear_obs();
    req_valid = 4'b0010; req_data[1*W +: W] = 32'hFFFF_FFFF;
    cycle();
    req_valid = 4'b1000; req_data[3*W +: W] = 32'h0;
    cycle();
    idle(4);
    check_val("edge_count", obs_gray.size(), 2);
    if (obs_gray.size() >= 2) begin
      check_val("ones_gray", obs_gray[0], 32'h0);
      check_val("ones_wrap", obs_wrap[0], 1);
      check_val("zero_gray", obs_gray[1], 32'h1);
      check_val("zero_wrap", obs_wrap[1], 0);
    end

    // round-robin under full load from a fresh pointer
    reset = 1'b1; cycle(); reset = 1'b0;
    clear_obs();
    req_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < N; k++) req_data[k*W +: W] = $urandom;
      cycle();
    end
    idle(3);
    check_val("rr_count", obs_id.size(), 6);
    for (int i = 0; i < 6 && i < obs_id.size(); i++) check_val("rr_id", obs_id[i], exp_ids[i]);

    // stall with the pipe full: outputs frozen, nothing accepted
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < N; k++) req_data[k*W +: W] = $urandom;
      cycle();
    end
    rsp_ready = 1'b0;
    s_gray = rsp_gray; s_id = int'(rsp_id); s_wrap = rsp_wrap;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_val("stall_gray", rsp_gray, s_gray);
      check_val("stall_id", rsp_id, s_id);
      check_val("stall_wrap", rsp_wrap, s_wrap);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    idle(3);

    // reset with two operands in flight
    req_valid = 4'b0001;
    cycle(); cycle();
    reset = 1'b1; req_valid = 4'b1111;
    cycle();
    reset = 1'b0; req_valid = 4'b1010;
    cycle();
    idle(3);

    // randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      reset     = ($urandom_range(99) == 0);
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(9) < 7);
      for (int k = 0; k < N; k++)
        req_data[k*W +: W] = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle();
    end
    reset = 1'b0;
    idle(4);

    // operand sweep through requester 2: successive responses one bit apart
    sweep_mode = 1'b1; have_prev = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    for (int n = 0; n < 65536; n++) begin
      req_data[2*W +: W] = 32'(n);
      cycle();
    end
    idle(4);
    sweep_mode = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
